// File: rtl/mem_responder.sv
// Single-port word memory shared by the instruction and data ports through a
// three-state handshake FSM. Define MEM_RANGE_CHECK_EN to flag and block out-of-range addresses.
module mem_responder #(
  parameter int MEM_WIDTH = 32,
  parameter int MEM_SIZE  = 256
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          mem_addr_instr,
  input  logic                 mem_read_en_instr,
  output logic [MEM_WIDTH-1:0] mem_read_val_instr,
  output logic                 mem_ack_instr,
  input  logic [31:0]          mem_addr_data,
  input  logic                 mem_read_en_data,
  input  logic                 mem_write_en_data,
  input  logic [MEM_WIDTH-1:0] mem_write_val_data,
  output logic [MEM_WIDTH-1:0] mem_read_val_data,
  output logic                 mem_ack_data,
  output logic                 mem_err
);
  localparam int IDX_W = $clog2(MEM_SIZE);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t                 state_q, state_d;
  logic                   sel_data_q, sel_data_d;
  logic                   last_data_q, last_data_d;
  logic                   is_wr_q, is_wr_d;
  logic [31:0]            addr_q, addr_d;
  logic [MEM_WIDTH-1:0]   wval_q, wval_d;
  logic [MEM_WIDTH-1:0]   rv_instr_q, rv_instr_d;
  logic [MEM_WIDTH-1:0]   rv_data_q, rv_data_d;
  logic                   ack_instr_q, ack_instr_d;
  logic                   ack_data_q, ack_data_d;
  logic                   err_q, err_d;

  logic [MEM_WIDTH-1:0]   mem [MEM_SIZE];
  logic [IDX_W-1:0]       idx;
  logic                   in_range;
  logic [MEM_WIDTH-1:0]   rd_word;
  logic                   pend_instr, pend_data, grant_data;

  assign idx = addr_q[IDX_W-1:0];
`ifdef MEM_RANGE_CHECK_EN
  assign in_range = (addr_q >> IDX_W) == 32'd0;
`else
  assign in_range = 1'b1;
`endif
  assign rd_word    = in_range ? mem[idx] : '0;
  assign pend_instr = mem_read_en_instr;
  assign pend_data  = mem_read_en_data | mem_write_en_data;
  // The round-robin pointer only moves on ties, so a lone grant never steals
  // the other port's turn at the next contention.
  assign grant_data = pend_data & (~pend_instr | ~last_data_q);

  always_comb begin
    state_d     = state_q;
    sel_data_d  = sel_data_q;
    last_data_d = last_data_q;
    is_wr_d     = is_wr_q;
    addr_d      = addr_q;
    wval_d      = wval_q;
    rv_instr_d  = rv_instr_q;
    rv_data_d   = rv_data_q;
    ack_instr_d = 1'b0;
    ack_data_d  = 1'b0;
    err_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (pend_instr | pend_data) begin
          state_d    = ACCESS;
          sel_data_d = grant_data;
          addr_d     = grant_data ? mem_addr_data : mem_addr_instr;
          is_wr_d    = grant_data & mem_write_en_data;
          wval_d     = mem_write_val_data;
          if (pend_instr & pend_data) last_data_d = grant_data;
        end
      end
      ACCESS: begin
        state_d = RESP;
        err_d   = ~in_range;
        if (sel_data_q) ack_data_d  = 1'b1;
        else            ack_instr_d = 1'b1;
        if (!is_wr_q) begin
          if (sel_data_q) rv_data_d  = rd_word;
          else            rv_instr_d = rd_word;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      sel_data_q  <= 1'b0;
      last_data_q <= 1'b1;
      is_wr_q     <= 1'b0;
      addr_q      <= '0;
      wval_q      <= '0;
      rv_instr_q  <= '0;
      rv_data_q   <= '0;
      ack_instr_q <= 1'b0;
      ack_data_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_data_q  <= sel_data_d;
      last_data_q <= last_data_d;
      is_wr_q     <= is_wr_d;
      addr_q      <= addr_d;
      wval_q      <= wval_d;
      rv_instr_q  <= rv_instr_d;
      rv_data_q   <= rv_data_d;
      ack_instr_q <= ack_instr_d;
      ack_data_q  <= ack_data_d;
      err_q       <= err_d;
    end
  end

  // Array has no reset; a write coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (!reset && state_q == ACCESS && is_wr_q && in_range)
      mem[idx] <= wval_q;
  end

  assign mem_read_val_instr = rv_instr_q;
  assign mem_read_val_data  = rv_data_q;
  assign mem_ack_instr      = ack_instr_q & ~reset;
  assign mem_ack_data       = ack_data_q & ~reset;
`ifdef MEM_RANGE_CHECK_EN
  assign mem_err            = err_q & ~reset;
`else
  assign mem_err            = 1'b0;
`endif
endmodule

// File: tb/tb_mem_responder.sv
// Directed + randomized bench for mem_responder against a word-array reference model.
module tb_mem_responder;
  localparam int W = 32;
  localparam int SZ = 256;

  logic          clk = 1'b0;
  logic          reset;
  logic [31:0]   mem_addr_instr, mem_addr_data;
  logic          mem_read_en_instr, mem_read_en_data, mem_write_en_data;
  logic [W-1:0]  mem_write_val_data;
  logic [W-1:0]  mem_read_val_instr, mem_read_val_data;
  logic          mem_ack_instr, mem_ack_data, mem_err;

  mem_responder #(.MEM_WIDTH(W), .MEM_SIZE(SZ)) dut (
    .clk(clk), .reset(reset),
    .mem_addr_instr(mem_addr_instr), .mem_read_en_instr(mem_read_en_instr),
    .mem_read_val_instr(mem_read_val_instr), .mem_ack_instr(mem_ack_instr),
    .mem_addr_data(mem_addr_data), .mem_read_en_data(mem_read_en_data),
    .mem_write_en_data(mem_write_en_data), .mem_write_val_data(mem_write_val_data),
    .mem_read_val_data(mem_read_val_data), .mem_ack_data(mem_ack_data),
    .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // reference model
  logic [W-1:0] mdl [SZ];
  logic [W-1:0] exp_rv_i, exp_rv_d;
  bit           last_tie_data;

  function automatic bit in_rng(input logic [31:0] a);
`ifdef MEM_RANGE_CHECK_EN
    return a < SZ;
`else
    return 1'b1;
`endif
  endfunction

  // Returns the value a read should observe and updates the model for writes.
  function automatic logic [W-1:0] apply(input bit is_wr, input logic [31:0] a,
                                         input logic [W-1:0] wv);
    int i;
    i = int'(a % SZ);
    if (is_wr) begin
      if (in_rng(a)) mdl[i] = wv;
      return '0;
    end
    return in_rng(a) ? mdl[i] : '0;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    mem_read_en_instr = 0; mem_read_en_data = 0; mem_write_en_data = 0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    idle_inputs();
    reset = 1;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    exp_rv_i = '0; exp_rv_d = '0; last_tie_data = 1'b1;
  endtask

  task automatic do_op(input string tag, input bit pdata, input bit re, input bit we,
                       input logic [31:0] a, input logic [W-1:0] wv);
    int lat;
    bit ok, wr;
    logic [W-1:0] rv;
    @(posedge clk); #1;
    if (pdata) begin
      mem_addr_data = a; mem_read_en_data = re; mem_write_en_data = we;
      mem_write_val_data = wv;
    end else begin
      mem_addr_instr = a; mem_read_en_instr = 1'b1;
    end
    lat = 0;
    for (int n = 1; n <= 8 && lat == 0; n++) begin
      @(posedge clk); #1;
      if (pdata ? mem_ack_data : mem_ack_instr) lat = n;
    end
    chk({tag, " latency"}, lat, 2);
    ok = in_rng(a);
    wr = pdata & we;
    rv = apply(wr, a, wv);
    if (!wr) begin
      if (pdata) exp_rv_d = rv; else exp_rv_i = rv;
    end
    chk({tag, " other_ack"}, pdata ? mem_ack_instr : mem_ack_data, 0);
    chk({tag, " err"}, mem_err, {63'd0, ~ok});
    chk({tag, " rv_instr"}, mem_read_val_instr, exp_rv_i);
    chk({tag, " rv_data"}, mem_read_val_data, exp_rv_d);
    idle_inputs();
    @(posedge clk); #1;
    chk({tag, " ack_pulse"}, {mem_ack_instr, mem_ack_data}, 0);
  endtask

  task automatic do_tie(input string tag, input logic [31:0] ai, input logic [31:0] ad,
                        input bit dwe, input logic [W-1:0] wv);
    int ci, cd;
    bit both, win_d;
    logic [W-1:0] rv;
    win_d = ~last_tie_data;
    ci = 0; cd = 0; both = 0;
    @(posedge clk); #1;
    mem_addr_instr = ai; mem_read_en_instr = 1;
    mem_addr_data = ad; mem_read_en_data = ~dwe; mem_write_en_data = dwe;
    mem_write_val_data = wv;
    for (int n = 1; n <= 9; n++) begin
      @(posedge clk); #1;
      if (mem_ack_instr && mem_ack_data) both = 1;
      if (mem_ack_instr && ci == 0) begin ci = n; mem_read_en_instr = 0; end
      if (mem_ack_data && cd == 0) begin
        cd = n; mem_read_en_data = 0; mem_write_en_data = 0;
      end
    end
    chk({tag, " both_ack"}, both, 0);
    chk({tag, " instr_cycle"}, ci, win_d ? 5 : 2);
    chk({tag, " data_cycle"}, cd, win_d ? 2 : 5);
    if (win_d) begin
      rv = apply(dwe, ad, wv); if (!dwe) exp_rv_d = rv;
      exp_rv_i = apply(0, ai, '0);
    end else begin
      exp_rv_i = apply(0, ai, '0);
      rv = apply(dwe, ad, wv); if (!dwe) exp_rv_d = rv;
    end
    chk({tag, " rv_instr"}, mem_read_val_instr, exp_rv_i);
    chk({tag, " rv_data"}, mem_read_val_data, exp_rv_d);
    last_tie_data = win_d;
    idle_inputs();
  endtask

  initial begin
    logic [31:0] a;
    logic [W-1:0] v;
    bit pd, re, we;
    reset = 1;
    mem_addr_instr = 0; mem_addr_data = 0; mem_write_val_data = 0;
    idle_inputs();
    do_reset();

    repeat (5) begin
      @(posedge clk); #1;
      chk("reset acks", {mem_ack_instr, mem_ack_data}, 0);
      chk("reset err", mem_err, 0);
      chk("reset rvs", {mem_read_val_instr, mem_read_val_data}, 0);
    end

    for (int i = 0; i < 16; i++) do_op("prefill", 1, 0, 1, i, $urandom);

    do_op("wr5", 1, 0, 1, 5, 32'hDEADBEEF);
    do_op("rd5", 0, 1, 0, 5, 0);
    chk("rd5 value", mem_read_val_instr, 32'hDEADBEEF);

    do_op("wr3", 1, 0, 1, 3, 32'h11);
    do_op("wr7", 1, 0, 1, 7, 32'h22);
    do_reset();
    do_tie("tie1", 3, 7, 0, 0);
    chk("tie1 i", mem_read_val_instr, 32'h11);
    chk("tie1 d", mem_read_val_data, 32'h22);
    do_tie("tie2", 7, 3, 0, 0);
    do_tie("tie3", 5, 11, 1, $urandom);

    do_op("rw9", 1, 1, 1, 9, 32'h1234);
    do_op("rd9", 0, 1, 0, 9, 0);
    chk("rd9 value", mem_read_val_instr, 32'h1234);

    do_op("wr260", 1, 0, 1, 260, 32'hA5A5_0104);
    do_op("rd4", 0, 1, 0, 4, 0);
    do_op("rd260", 1, 1, 0, 260, 0);

    for (int i = 0; i < 30; i++) begin
      a = $urandom_range(0, 15);
`ifndef MEM_RANGE_CHECK_EN
      if ($urandom_range(0, 3) == 0) a = a + SZ * $urandom_range(1, 1000);
`endif
      v = $urandom;
      pd = $urandom_range(0, 1);
      we = $urandom_range(0, 1);
      re = we ? bit'($urandom_range(0, 1)) : 1'b1;
      if ($urandom_range(0, 4) == 0) do_tie("rtie", $urandom_range(0, 15), a, we, v);
      else do_op("rnd", pd, re, we, a, v);
    end

    // reset landing on the ACCESS edge of a write
    do_op("pre2", 1, 0, 1, 2, 32'h77);
    @(posedge clk); #1;
    mem_addr_data = 2; mem_write_en_data = 1; mem_write_val_data = 32'h55;
    @(posedge clk); #1;
    reset = 1;
    @(posedge clk); #1;
    chk("rst_access ack", {mem_ack_instr, mem_ack_data}, 0);
    reset = 0;
    idle_inputs();
    exp_rv_i = '0; exp_rv_d = '0; last_tie_data = 1'b1;
    chk("rst_access rvs", {mem_read_val_instr, mem_read_val_data}, 0);
    @(posedge clk); #1;
    chk("rst_access idle ack", {mem_ack_instr, mem_ack_data}, 0);
    do_op("rd2", 0, 1, 0, 2, 0);
    chk("rd2 value", mem_read_val_instr, 32'h77);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
